// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/interrupt/mret sequencer with pipeline flush and PC redirect
module trap_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic        retire_valid_i,
    input  logic [31:0] retire_pc_i,
    input  logic        xint_meip_i,
    input  logic        xint_mtip_i,
    input  logic        xint_msip_i,
    input  logic [2:0]  mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        csr_mstatus_we_i,
    input  logic [31:0] csr_mstatus_d_i,
    output logic        mstatus_mie_o,
    output logic        mstatus_mpie_o,
    output logic [2:0]  mip_o,
    output logic        trap_we_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtval_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    state_t      state_q, state_d;
    logic [2:0]  sync1_q, sync2_q;
    logic        mie_q, mpie_q;
    logic        is_int_q, is_mret_q;
    logic [3:0]  cause_q;
    logic [31:0] mepc_q, mtval_q, redirect_pc_q;

    logic [2:0]  int_pending;
    logic        int_ok;
    logic [3:0]  int_cause;
    logic        take_exc, take_int, take_mret;
    logic [31:0] tvec_base;

    // Bits of the inputs that this block has no use for
    logic unused_bits;
    assign unused_bits = ^{csr_mstatus_d_i[31:8], csr_mstatus_d_i[6:4], csr_mstatus_d_i[2:0],
                           mepc_i[1:0], exc_pc_i[1:0], retire_pc_i[1:0]};

    // Two-flop synchronizers for the asynchronous interrupt lines {MEIP, MTIP, MSIP}
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {xint_meip_i, xint_mtip_i, xint_msip_i};
            sync2_q <= sync1_q;
        end
    end

    // Event arbitration in IDLE: exception beats interrupt beats mret; MEI > MSI > MTI
    always_comb begin
        int_pending = sync2_q & mie_i;
        int_ok      = retire_valid_i && mie_q && (int_pending != 3'b000);
        int_cause   = int_pending[2] ? CAUSE_MEI :
                      int_pending[0] ? CAUSE_MSI : CAUSE_MTI;
        take_exc    = (state_q == ST_IDLE) && exc_valid_i;
        take_int    = (state_q == ST_IDLE) && !exc_valid_i && int_ok;
        take_mret   = (state_q == ST_IDLE) && !exc_valid_i && !int_ok && mret_i;
        tvec_base   = {mtvec_i[31:2], 2'b00};
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (take_exc || take_int || take_mret) state_d = ST_FLUSH;
            ST_FLUSH:    state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; the CSR write strobe is suppressed for mret
    always_comb begin
        flush_o          = (state_q == ST_FLUSH);
        trap_we_o        = (state_q == ST_FLUSH) && !is_mret_q;
        redirect_valid_o = (state_q == ST_REDIRECT);
        busy_o           = (state_q != ST_IDLE);
    end

    // Capture the accepted event; trap CSR values are presented during FLUSH
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b0;
            cause_q   <= 4'd0;
            mepc_q    <= 32'd0;
            mtval_q   <= 32'd0;
        end else if (take_exc) begin
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b0;
            cause_q   <= exc_cause_i;
            mepc_q    <= {exc_pc_i[31:2], 2'b00};
            mtval_q   <= exc_tval_i;
        end else if (take_int) begin
            is_int_q  <= 1'b1;
            is_mret_q <= 1'b0;
            cause_q   <= int_cause;
            mepc_q    <= {retire_pc_i[31:2], 2'b00};
            mtval_q   <= 32'd0;
        end else if (take_mret) begin
            is_mret_q <= 1'b1;
        end
    end

    // Redirect target is latched on leaving FLUSH so it stays stable under backpressure
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            redirect_pc_q <= 32'd0;
        end else if (state_q == ST_FLUSH) begin
            if (is_mret_q) begin
                redirect_pc_q <= {mepc_i[31:2], 2'b00};
            end else if (is_int_q && (mtvec_i[1:0] == 2'b01)) begin
                redirect_pc_q <= tvec_base + {26'd0, cause_q, 2'b00};
            end else begin
                redirect_pc_q <= tvec_base;
            end
        end
    end

    // mstatus MIE/MPIE: trap and mret updates take precedence over a software write
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (take_exc || take_int) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (take_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (csr_mstatus_we_i) begin
            mie_q  <= csr_mstatus_d_i[3];
            mpie_q <= csr_mstatus_d_i[7];
        end
    end

    assign mstatus_mie_o  = mie_q;
    assign mstatus_mpie_o = mpie_q;
    assign mip_o          = sync2_q;
    assign mcause_o       = {is_int_q, 27'd0, cause_q};
    assign mepc_o         = mepc_q;
    assign mtval_o        = mtval_q;
    assign redirect_pc_o  = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed and randomized check of trap_ctrl against a transaction-level model
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exc_valid_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i;
    logic        mret_i, retire_valid_i;
    logic [31:0] retire_pc_i;
    logic        xint_meip_i, xint_mtip_i, xint_msip_i;
    logic [2:0]  mie_i;
    logic [31:0] mtvec_i, mepc_i;
    logic        csr_mstatus_we_i;
    logic [31:0] csr_mstatus_d_i;
    logic        redirect_ready_i;
    logic        mstatus_mie_o, mstatus_mpie_o;
    logic [2:0]  mip_o;
    logic        trap_we_o, flush_o, redirect_valid_o, busy_o;
    logic [31:0] mcause_o, mepc_o, mtval_o, redirect_pc_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: line history, mstatus bits, current sequence phase and its payload
    logic [2:0]  m_line [2];
    logic        m_mie, m_mpie;
    int          m_phase;   // 0 idle, 1 flush, 2 redirect
    int          m_kind;    // 0 exception, 1 interrupt, 2 mret
    int          m_code;
    logic [31:0] m_mcause, m_epc, m_tval, m_rpc;

    always #5 clk_i = ~clk_i;

    trap_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
        .xint_meip_i(xint_meip_i), .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i),
        .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_mstatus_we_i(csr_mstatus_we_i), .csr_mstatus_d_i(csr_mstatus_d_i),
        .mstatus_mie_o(mstatus_mie_o), .mstatus_mpie_o(mstatus_mpie_o), .mip_o(mip_o),
        .trap_we_o(trap_we_o), .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_kind  = 0;
        m_mie   = 1'b0;
        m_mpie  = 1'b0;
        m_line[0] = 3'b000;
        m_line[1] = 3'b000;
    endtask

    // One rising edge of the model, using the inputs as they stood before the edge
    task automatic model_clock();
        logic [2:0] pend;
        bit took;
        int prio_bit[3];
        int prio_code[3];
        prio_bit  = '{2, 0, 1};
        prio_code = '{11, 3, 7};
        if (!rst_i) begin
            model_reset();
            return;
        end
        pend = m_line[1] & mie_i;
        took = 0;
        if (m_phase == 0) begin
            if (exc_valid_i) begin
                m_kind = 0; m_code = int'(exc_cause_i);
                m_mcause = 32'(m_code); m_epc = exc_pc_i & ~32'h3; m_tval = exc_tval_i;
                took = 1;
            end else if (retire_valid_i && m_mie && pend != 3'b000) begin
                m_kind = 1;
                for (int i = 2; i >= 0; i--) if (pend[prio_bit[i]]) m_code = prio_code[i];
                m_mcause = 32'h8000_0000 | 32'(m_code); m_epc = retire_pc_i & ~32'h3; m_tval = 0;
                took = 1;
            end else if (mret_i) begin
                m_kind = 2;
                took = 1;
            end
            if (took) begin
                m_phase = 1;
                if (m_kind == 2) begin
                    m_mie = m_mpie; m_mpie = 1'b1;
                end else begin
                    m_mpie = m_mie; m_mie = 1'b0;
                end
            end
        end else if (m_phase == 1) begin
            if (m_kind == 2)                            m_rpc = mepc_i & ~32'h3;
            else if (m_kind == 1 && mtvec_i[1:0] == 2'b01) m_rpc = (mtvec_i & ~32'h3) + 32'(4 * m_code);
            else                                        m_rpc = mtvec_i & ~32'h3;
            m_phase = 2;
        end else if (redirect_ready_i) begin
            m_phase = 0;
        end
        if (!took && csr_mstatus_we_i) begin
            m_mie  = csr_mstatus_d_i[3];
            m_mpie = csr_mstatus_d_i[7];
        end
        m_line[1] = m_line[0];
        m_line[0] = {xint_meip_i, xint_mtip_i, xint_msip_i};
    endtask

    task automatic compare_all();
        chk("busy", busy_o, m_phase != 0);
        chk("flush", flush_o, m_phase == 1);
        chk("trap_we", trap_we_o, m_phase == 1 && m_kind != 2);
        chk("redirect_valid", redirect_valid_o, m_phase == 2);
        chk("mie", mstatus_mie_o, m_mie);
        chk("mpie", mstatus_mpie_o, m_mpie);
        chk("mip", mip_o, m_line[1]);
        if (m_phase == 1 && m_kind != 2) begin
            chk("mcause", mcause_o, m_mcause);
            chk("mepc", mepc_o, m_epc);
            chk("mtval", mtval_o, m_tval);
        end
        if (m_phase == 2) chk("redirect_pc", redirect_pc_o, m_rpc);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mie"}, mstatus_mie_o, 0);
        chk({tag, "_mpie"}, mstatus_mpie_o, 0);
        chk({tag, "_mip"}, mip_o, 0);
        chk({tag, "_trap_we"}, trap_we_o, 0);
        chk({tag, "_mcause"}, mcause_o, 0);
        chk({tag, "_mepc"}, mepc_o, 0);
        chk({tag, "_mtval"}, mtval_o, 0);
        chk({tag, "_flush"}, flush_o, 0);
        chk({tag, "_rvalid"}, redirect_valid_o, 0);
        chk({tag, "_rpc"}, redirect_pc_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic csr_write(input logic [31:0] d);
        csr_mstatus_we_i = 1'b1; csr_mstatus_d_i = d;
        step();
        csr_mstatus_we_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; exc_valid_i = 0; exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0;
        mret_i = 0; retire_valid_i = 0; retire_pc_i = 0;
        xint_meip_i = 0; xint_mtip_i = 0; xint_msip_i = 1;
        mie_i = 0; mtvec_i = 0; mepc_i = 0; csr_mstatus_we_i = 0; csr_mstatus_d_i = 0;
        redirect_ready_i = 1;
        model_reset();
        step(); step();
        chk_all_zero("reset");
        xint_msip_i = 0;
        #2 rst_i = 1'b1;
        step(); step();

        // Synchronous exception into a direct-mode vector
        mtvec_i = 32'h8000_0000;
        exc_valid_i = 1; exc_cause_i = 4'd2; exc_pc_i = 32'h100; exc_tval_i = 32'h13;
        step();
        exc_valid_i = 0;
        chk("exc_trap_we", trap_we_o, 1);
        chk("exc_mcause", mcause_o, 32'h2);
        chk("exc_mepc", mepc_o, 32'h100);
        chk("exc_mtval", mtval_o, 32'h13);
        chk("exc_mie", mstatus_mie_o, 0);
        step();
        chk("exc_rpc", redirect_pc_o, 32'h8000_0000);
        step();
        chk("exc_idle", busy_o, 0);

        // MRET with MPIE=1, MIE=0
        csr_write(32'h80);
        mepc_i = 32'h204; mret_i = 1;
        step();
        mret_i = 0;
        chk("mret_trap_we", trap_we_o, 0);
        chk("mret_flush", flush_o, 1);
        chk("mret_mie", mstatus_mie_o, 1);
        chk("mret_mpie", mstatus_mpie_o, 1);
        step();
        chk("mret_rpc", redirect_pc_o, 32'h204);
        step();

        // Vectored interrupt, MEI and MTI raised together
        mie_i = 3'b111; mtvec_i = 32'h8000_0001; retire_valid_i = 1; retire_pc_i = 32'h3002;
        xint_meip_i = 1; xint_mtip_i = 1;
        step();
        chk("vi_mip_sync1", mip_o, 3'b000);
        step();
        chk("vi_mip_sync2", mip_o, 3'b110);
        step();
        chk("vi_trap_we", trap_we_o, 1);
        chk("vi_mcause", mcause_o, 32'h8000_000B);
        chk("vi_mepc", mepc_o, 32'h3000);
        chk("vi_mtval", mtval_o, 32'h0);
        step();
        chk("vi_rpc", redirect_pc_o, 32'h8000_002C);
        xint_meip_i = 0; xint_mtip_i = 0; retire_valid_i = 0;
        step(); step(); step();

        // Exception, mret and qualified MSI together; MSI later once re-enabled
        mie_i = 3'b001; xint_msip_i = 1;
        csr_write(32'h08);
        step(); step();
        exc_valid_i = 1; exc_cause_i = 4'd4; exc_pc_i = 32'h400; exc_tval_i = 32'h55;
        mret_i = 1; retire_valid_i = 1; retire_pc_i = 32'h440;
        step();
        exc_valid_i = 0; mret_i = 0;
        chk("sim_trap_we", trap_we_o, 1);
        chk("sim_mcause", mcause_o, 32'h4);
        step(); step();
        chk("sim_idle", busy_o, 0);
        csr_write(32'h08);
        step();
        chk("sim_msi_trap_we", trap_we_o, 1);
        chk("sim_msi_mcause", mcause_o, 32'h8000_0003);
        step();
        chk("sim_msi_rpc", redirect_pc_o, 32'h8000_000C);
        retire_valid_i = 0; xint_msip_i = 0;
        step(); step(); step();

        // Backpressure on the redirect handshake
        redirect_ready_i = 0; mtvec_i = 32'h8000_0000;
        exc_valid_i = 1; exc_cause_i = 4'd6; exc_pc_i = 32'h500; exc_tval_i = 32'h0;
        step();
        exc_valid_i = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            exc_valid_i = 1; exc_pc_i = 32'h600 + 32'(i * 4);
            step();
            chk("bp_busy", busy_o, 1);
            chk("bp_rvalid", redirect_valid_o, 1);
            chk("bp_rpc", redirect_pc_o, 32'h8000_0000);
        end
        exc_valid_i = 0; redirect_ready_i = 1;
        step();
        chk("bp_idle", busy_o, 0);

        // Reset while in REDIRECT
        csr_write(32'h08);
        redirect_ready_i = 0;
        exc_valid_i = 1; exc_cause_i = 4'd0; exc_pc_i = 32'h700;
        step();
        exc_valid_i = 0;
        step();
        chk("rr_in_redirect", redirect_valid_o, 1);
        #1 rst_i = 1'b0;
        model_reset();
        #1;
        chk_all_zero("rr");
        step();
        #2 rst_i = 1'b1; redirect_ready_i = 1;
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            exc_valid_i      = ($urandom_range(0, 7) == 0);
            exc_cause_i      = 4'($urandom_range(0, 3) * 2);
            exc_pc_i         = $urandom;
            exc_tval_i       = $urandom;
            mret_i           = ($urandom_range(0, 7) == 0);
            retire_valid_i   = $urandom_range(0, 1) == 1;
            retire_pc_i      = $urandom;
            if ($urandom_range(0, 15) == 0) xint_meip_i = ~xint_meip_i;
            if ($urandom_range(0, 15) == 0) xint_mtip_i = ~xint_mtip_i;
            if ($urandom_range(0, 15) == 0) xint_msip_i = ~xint_msip_i;
            if ($urandom_range(0, 31) == 0) mie_i = 3'($urandom);
            if ($urandom_range(0, 15) == 0) mtvec_i = {$urandom_range(0, 32'h3FFF_FFFF), 1'b0, 1'($urandom)};
            if ($urandom_range(0, 15) == 0) mepc_i = $urandom;
            csr_mstatus_we_i = ($urandom_range(0, 9) == 0);
            csr_mstatus_d_i  = $urandom;
            redirect_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_i = 1'b0;
                model_reset();
                #1;
                compare_all();
                step();
                #2 rst_i = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  core clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: exc_valid_i  in  1  synchronous exception reported by write-back (single-cycle pulse).
REQ-004 SHALL have ports: exc_cause_i  in  4  exception code (0, 2, 4 or 6).
REQ-005 SHALL have ports: exc_pc_i  in  32  PC of the faulting instruction.
REQ-006 SHALL have ports: exc_tval_i  in  32  trap value.
REQ-007 SHALL have ports: mret_i  in  1  MRET retiring in write-back.
REQ-008 SHALL have ports: retire_valid_i  in  1  an instruction boundary is available; retire_pc_i  in  32  PC of the next instruction to retire.
REQ-009 SHALL have ports: xint_meip_i, xint_mtip_i, xint_msip_i  in  1 each  asynchronous level interrupt lines.
REQ-010 SHALL have ports: mie_i  in  3  enables {MEIE, MTIE, MSIE}; mtvec_i  in  32; mepc_i  in  32.
REQ-011 SHALL have ports: csr_mstatus_we_i  in  1; csr_mstatus_d_i  in  32  software write of mstatus (bit 3 MIE, bit 7 MPIE).
REQ-012 SHALL have ports: mstatus_mie_o, mstatus_mpie_o  out  1 each; mip_o  out  3  synchronized {MEIP, MTIP, MSIP}.
REQ-013 SHALL have ports: trap_we_o  out  1; mcause_o, mepc_o, mtval_o  out  32 each  trap CSR update to the CSR file.
REQ-014 SHALL have ports: flush_o  out  1; redirect_valid_o  out  1; redirect_pc_o  out  32; redirect_ready_i  in  1; busy_o  out  1.

Function
REQ-015 SHALL pass each xint line through a 2-flop synchronizer; mip_o SHALL reflect the second flop, so a line change becomes visible 2 cycles later.
REQ-016 SHALL implement the FSM IDLE -> FLUSH -> REDIRECT -> IDLE; busy_o SHALL be 1 in any state other than IDLE.
REQ-017 In IDLE, event priority SHALL be: exc_valid_i first, then a qualified interrupt, then mret_i; exactly one event SHALL be accepted per cycle.
REQ-018 An interrupt SHALL qualify only when retire_valid_i=1, mstatus_mie_o=1 and (mip_o & mie_i)!=0.
REQ-019 Interrupt priority SHALL be MEI (cause 11) > MSI (cause 3) > MTI (cause 7); mcause_o bit 31 SHALL be 1 for interrupts and 0 for exceptions.
REQ-020 On an accepted exception or interrupt, the block SHALL, in the next cycle (state FLUSH):
  - pulse trap_we_o=1 for exactly one cycle;
  - drive mepc_o = exc_pc_i (exception) or retire_pc_i (interrupt), with bits [1:0] forced to 0;
  - drive mtval_o = exc_tval_i (exception) or 0 (interrupt);
  - set MPIE<=MIE and MIE<=0.
REQ-021 On an accepted mret_i, the block SHALL enter FLUSH with trap_we_o=0, set MIE<=MPIE and MPIE<=1.
REQ-022 flush_o SHALL be 1 exactly in FLUSH (one cycle).
REQ-023 In REDIRECT, redirect_valid_o SHALL be 1, and redirect_pc_o SHALL be computed as follows:
  - mret: mepc_i & ~3;
  - trap with mtvec_i[1:0]=1 and an interrupt: (mtvec_i & ~3) + 4*cause, modulo 2^32;
  - otherwise: mtvec_i & ~3.
REQ-024 redirect_valid_o and redirect_pc_o SHALL be held stable until a cycle with redirect_ready_i=1; that cycle completes the handshake and the next state SHALL be IDLE.
REQ-025 exc_valid_i, mret_i and interrupts arriving while busy_o=1 SHALL be ignored; no queuing.
REQ-026 A csr_mstatus_we_i write SHALL update MIE/MPIE from bits 3/7, except in the cycle a trap or mret update occurs, where the trap/mret update SHALL win.
REQ-027 Interrupt lines deasserted before acceptance SHALL cause no trap.

Reset
REQ-028 On rst_i=0, asynchronously: state=IDLE; MIE=0, MPIE=0; synchronizers=0; all outputs 0.
REQ-029 Reset asserted mid-FLUSH or mid-REDIRECT SHALL abort the sequence with no further trap_we_o or redirect_valid_o.

Verification
REQ-030 Exception: exc_valid_i=1, cause=2, pc=0x100, tval=0x0000_0013, mtvec=0x8000_0000 -> next cycle trap_we_o=1, mcause=2, mepc=0x100, mtval=0x13, MIE=0; following cycle redirect_pc_o=0x8000_0000.
REQ-031 Vectored interrupt: MIE=1, mie_i=3'b111, mtvec=0x8000_0001, MEIP and MTIP raised together -> 2-cycle sync, then mcause=0x8000_000B, redirect_pc_o=0x8000_002C.
REQ-032 MRET: MPIE=1, MIE=0, mepc_i=0x204 -> no trap_we_o, MIE=1, MPIE=1, redirect_pc_o=0x204.
REQ-033 Simultaneous: exc_valid_i, mret_i and a qualified MSI in the same cycle -> exception only taken; MSI taken after return to IDLE if still pending.
REQ-034 Backpressure: redirect_ready_i=0 for 5 cycles -> redirect_valid_o and redirect_pc_o stable, busy_o=1, new exc_valid_i ignored; IDLE the cycle after ready=1.
REQ-035 Reset: rst_i=0 during REDIRECT -> redirect_valid_o=0 immediately, state IDLE, MIE=0.
